// File: rtl/min_reduce_ctrl_if.sv
// Handshake bundle for min_reduce_ctrl: start/busy control, element stream in, result out.
// MIN_REDUCE_ARGMIN_EN adds out_idx and its width parameter.
interface min_reduce_ctrl_if
`ifdef MIN_REDUCE_ARGMIN_EN
  #(parameter int IDX_W = 4)
`endif
  ();
  logic        start;
  logic        busy;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef MIN_REDUCE_ARGMIN_EN
  logic [IDX_W-1:0] out_idx;

  modport master (
    output start, in_data, in_valid, out_ready,
    input  busy, in_ready, out_data, out_valid, out_idx
  );
  modport slave (
    input  start, in_data, in_valid, out_ready,
    output busy, in_ready, out_data, out_valid, out_idx
  );
`else
  modport master (
    output start, in_data, in_valid, out_ready,
    input  busy, in_ready, out_data, out_valid
  );
  modport slave (
    input  start, in_data, in_valid, out_ready,
    output busy, in_ready, out_data, out_valid
  );
`endif
endinterface

// File: rtl/min_reduce_ctrl.sv
// Streams VEC_LEN float32 elements through one shared combinational min unit and returns the minimum.
// Optional argmin output compiled in with MIN_REDUCE_ARGMIN_EN.

// Float32 minimum: a NaN operand yields the other operand, -0 orders below +0.
module fp32_min (
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  output logic [31:0] outputMin
);
  logic        aNan;
  logic        bNan;
  logic [31:0] keyA;
  logic [31:0] keyB;

  // Map sign-magnitude onto an unsigned key so a plain compare orders the values.
  assign aNan = (&inputA[30:23]) && (|inputA[22:0]);
  assign bNan = (&inputB[30:23]) && (|inputB[22:0]);
  assign keyA = inputA[31] ? {1'b0, ~inputA[30:0]} : {1'b1, inputA[30:0]};
  assign keyB = inputB[31] ? {1'b0, ~inputB[30:0]} : {1'b1, inputB[30:0]};

  always_comb begin
    outputMin = inputA;
    if (aNan) begin
      outputMin = inputB;
    end else if (bNan) begin
      outputMin = inputA;
    end else if (keyB < keyA) begin
      outputMin = inputB;
    end
  end
endmodule

module min_reduce_ctrl #(
  parameter int VEC_LEN = 16,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  min_reduce_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} stateT;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  stateT            stateReg, stateNext;
  logic [31:0]      accReg, accNext;
  logic [IDX_W-1:0] cntReg, cntNext;
  logic [31:0]      minOut;
  logic             inReady;
  logic             outValid;
  logic             busyOut;
`ifdef MIN_REDUCE_ARGMIN_EN
  logic [IDX_W-1:0] idxReg, idxNext;
`endif

  fp32_min minUnit (
    .inputA    (accReg),
    .inputB    (bus.in_data),
    .outputMin (minOut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      accReg   <= '0;
      cntReg   <= '0;
`ifdef MIN_REDUCE_ARGMIN_EN
      idxReg   <= '0;
`endif
    end else begin
      stateReg <= stateNext;
      accReg   <= accNext;
      cntReg   <= cntNext;
`ifdef MIN_REDUCE_ARGMIN_EN
      idxReg   <= idxNext;
`endif
    end
  end

  always_comb begin
    stateNext = stateReg;
    accNext   = accReg;
    cntNext   = cntReg;
    inReady   = 1'b0;
    outValid  = 1'b0;
    busyOut   = 1'b0;
`ifdef MIN_REDUCE_ARGMIN_EN
    idxNext   = idxReg;
`endif
    unique case (stateReg)
      IDLE: begin
        if (bus.start) begin
          stateNext = ACCUM;
          cntNext   = '0;
        end
      end
      ACCUM: begin
        inReady = 1'b1;
        busyOut = 1'b1;
        if (bus.in_valid) begin
          // The first element seeds the accumulator; later ones go through the min unit.
          if (cntReg == '0) begin
            accNext = bus.in_data;
`ifdef MIN_REDUCE_ARGMIN_EN
            idxNext = '0;
`endif
          end else begin
            accNext = minOut;
`ifdef MIN_REDUCE_ARGMIN_EN
            if (minOut != accReg) idxNext = cntReg;
`endif
          end
          cntNext = cntReg + 1'b1;
          if (cntReg == LAST_IDX) stateNext = DONE;
        end
      end
      DONE: begin
        outValid = 1'b1;
        busyOut  = 1'b1;
        if (bus.out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.busy      = busyOut;
  assign bus.out_data  = accReg;
`ifdef MIN_REDUCE_ARGMIN_EN
  assign bus.out_idx   = idxReg;
`endif
endmodule

// File: tb/tb_min_reduce_ctrl.sv
// Randomised and directed bench for min_reduce_ctrl (VEC_LEN=4) against a real-valued minimum model.
// Index checks are active when MIN_REDUCE_ARGMIN_EN is defined.
module tb_min_reduce_ctrl;
  localparam int VEC_LEN = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef MIN_REDUCE_ARGMIN_EN
  localparam int IDX_W = $clog2(VEC_LEN);
  min_reduce_ctrl_if #(.IDX_W(IDX_W)) bus ();
`else
  min_reduce_ctrl_if bus ();
`endif

  min_reduce_ctrl #(.VEC_LEN(VEC_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] vec [VEC_LEN];
  logic [31:0] got_data;
  int          got_idx;
  int          got_lat;
  int          ready_miss;
  int          overlap;
  int          hold_bad;
  logic        end_busy, end_valid, end_ready;
  logic [31:0] exp_data;
  int          exp_idx;

  // float32 (normal values only) to real via the equivalent double encoding
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // Reference: smallest value by numeric comparison, earliest position on ties
  function automatic void ref_min(output logic [31:0] m, output int idx);
    m = vec[0];
    idx = 0;
    for (int k = 1; k < VEC_LEN; k++) begin
      if (f2r(vec[k]) < f2r(m)) begin
        m = vec[k];
        idx = k;
      end
    end
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f[31]    = 1'($urandom_range(0, 1));
    f[30:23] = 8'($urandom_range(100, 154));
    f[22:0]  = 23'($urandom);
    return f;
  endfunction

  // Starts a run, streams vec with 'gap' idle cycles before each element, waits for out_valid.
  task automatic feed_vector(input int gap, input bit poke_start, input bit valid_with_start);
    int cyc;
    ready_miss = 0;
    overlap    = 0;
    bus.start  = 1'b1;
    if (valid_with_start) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hFF800000;
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    cyc = 1;
    for (int k = 0; k < VEC_LEN; k++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.start    = poke_start;
        @(negedge clk);
        bus.start = 1'b0;
        cyc++;
      end
      if (bus.in_ready !== 1'b1) ready_miss++;
      bus.in_valid = 1'b1;
      bus.in_data  = vec[k];
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.in_ready !== 1'b0) overlap++;
    got_lat  = cyc - gap * VEC_LEN;
    got_data = bus.out_data;
`ifdef MIN_REDUCE_ARGMIN_EN
    got_idx = int'(bus.out_idx);
`else
    got_idx = 0;
`endif
  endtask

  // Holds out_ready low for 'hold' cycles watching stability, then completes the handshake.
  task automatic drain(input int hold, input bit poke_start);
    logic [31:0] d0;
    hold_bad = 0;
    d0 = bus.out_data;
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.start = poke_start;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_data !== d0 || bus.busy !== 1'b1) hold_bad++;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    end_busy  = bus.busy;
    end_valid = bus.out_valid;
    end_ready = bus.in_ready;
    $display("txn: data=%h idx=%0d lat=%0d hold=%0d", got_data, got_idx, got_lat, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
`ifdef MIN_REDUCE_ARGMIN_EN
    total++; if (bus.out_idx !== '0) begin bad++; $display("FAIL reset_out_idx: got %0d want 0", bus.out_idx); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    vec[0] = 32'h40400000; vec[1] = 32'hC0200000; vec[2] = 32'h3F800000; vec[3] = 32'hC0E00000;
    feed_vector(0, 1'b0, 1'b0);
    total++; if (got_lat != VEC_LEN + 1) begin bad++; $display("FAIL basic_latency: got %0d want %0d", got_lat, VEC_LEN + 1); end
    total++; if (got_data !== 32'hC0E00000) begin bad++; $display("FAIL basic_data: got %h want c0e00000", got_data); end
`ifdef MIN_REDUCE_ARGMIN_EN
    total++; if (got_idx != 3) begin bad++; $display("FAIL basic_idx: got %0d want 3", got_idx); end
`endif
    total++; if (ready_miss != 0) begin bad++; $display("FAIL basic_in_ready: got %0d misses want 0", ready_miss); end
    total++; if (overlap != 0) begin bad++; $display("FAIL basic_overlap: got %0d want 0", overlap); end
    drain(0, 1'b0);
    total++; if (end_busy !== 1'b0 || end_valid !== 1'b0) begin bad++; $display("FAIL basic_return_idle: got busy=%b valid=%b want 0 0", end_busy, end_valid); end
  endtask

  task automatic test_tie();
    for (int k = 0; k < VEC_LEN; k++) vec[k] = 32'h3F800000;
    feed_vector(0, 1'b0, 1'b0);
    total++; if (got_data !== 32'h3F800000) begin bad++; $display("FAIL tie_data: got %h want 3f800000", got_data); end
`ifdef MIN_REDUCE_ARGMIN_EN
    total++; if (got_idx != 0) begin bad++; $display("FAIL tie_idx: got %0d want 0", got_idx); end
`endif
    drain(0, 1'b0);
  endtask

  task automatic test_out_stall();
    vec[0] = 32'h40A00000; vec[1] = 32'h40000000; vec[2] = 32'hBF800000; vec[3] = 32'h41200000;
    feed_vector(0, 1'b0, 1'b0);
    total++; if (got_data !== 32'hBF800000) begin bad++; $display("FAIL stall_data: got %h want bf800000", got_data); end
    drain(5, 1'b0);
    total++; if (hold_bad != 0) begin bad++; $display("FAIL stall_hold: got %0d bad cycles want 0", hold_bad); end
    total++; if (end_busy !== 1'b0 || end_valid !== 1'b0 || end_ready !== 1'b0) begin
      bad++; $display("FAIL stall_release: got busy=%b valid=%b ready=%b want 0 0 0", end_busy, end_valid, end_ready);
    end
  endtask

  task automatic test_gaps();
    vec[0] = 32'h3F800000; vec[1] = 32'h40400000; vec[2] = 32'hC0200000; vec[3] = 32'h3F800000;
    feed_vector(2, 1'b0, 1'b0);
    total++; if (got_lat != VEC_LEN + 1) begin bad++; $display("FAIL gaps_latency: got %0d want %0d", got_lat, VEC_LEN + 1); end
    total++; if (got_data !== 32'hC0200000) begin bad++; $display("FAIL gaps_data: got %h want c0200000", got_data); end
`ifdef MIN_REDUCE_ARGMIN_EN
    total++; if (got_idx != 2) begin bad++; $display("FAIL gaps_idx: got %0d want 2", got_idx); end
`endif
    drain(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h40400000;
    @(negedge clk);
    bus.in_data = 32'h3F800000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl: got busy=%b ready=%b valid=%b want 0 0 0", bus.busy, bus.in_ready, bus.out_valid);
    end
    total++; if (bus.out_data !== 32'h0) begin bad++; $display("FAIL midrst_data: got %h want 0", bus.out_data); end
`ifdef MIN_REDUCE_ARGMIN_EN
    total++; if (bus.out_idx !== '0) begin bad++; $display("FAIL midrst_idx: got %0d want 0", bus.out_idx); end
`endif
    vec[0] = 32'h40400000; vec[1] = 32'h3F800000; vec[2] = 32'h40400000; vec[3] = 32'h40400000;
    feed_vector(0, 1'b0, 1'b0);
    total++; if (got_data !== 32'h3F800000) begin bad++; $display("FAIL midrst_rerun_data: got %h want 3f800000", got_data); end
`ifdef MIN_REDUCE_ARGMIN_EN
    total++; if (got_idx != 1) begin bad++; $display("FAIL midrst_rerun_idx: got %0d want 1", got_idx); end
`endif
    drain(0, 1'b0);
  endtask

  task automatic test_start_ignored();
    vec[0] = 32'hC1000000; vec[1] = 32'h40800000; vec[2] = 32'hC1100000; vec[3] = 32'hC0800000;
    ref_min(exp_data, exp_idx);
    feed_vector(1, 1'b1, 1'b0);
    total++; if (got_lat != VEC_LEN + 1) begin bad++; $display("FAIL startign_latency: got %0d want %0d", got_lat, VEC_LEN + 1); end
    total++; if (got_data !== exp_data) begin bad++; $display("FAIL startign_data: got %h want %h", got_data, exp_data); end
`ifdef MIN_REDUCE_ARGMIN_EN
    total++; if (got_idx != exp_idx) begin bad++; $display("FAIL startign_idx: got %0d want %0d", got_idx, exp_idx); end
`endif
    drain(3, 1'b1);
    total++; if (hold_bad != 0) begin bad++; $display("FAIL startign_done_hold: got %0d bad cycles want 0", hold_bad); end
  endtask

  task automatic test_start_with_valid();
    vec[0] = 32'h40000000; vec[1] = 32'h40400000; vec[2] = 32'h3F000000; vec[3] = 32'h40800000;
    feed_vector(0, 1'b0, 1'b1);
    total++; if (got_lat != VEC_LEN + 1) begin bad++; $display("FAIL startvalid_latency: got %0d want %0d", got_lat, VEC_LEN + 1); end
    total++; if (got_data !== 32'h3F000000) begin bad++; $display("FAIL startvalid_data: got %h want 3f000000", got_data); end
    drain(0, 1'b0);
  endtask

  task automatic test_random();
    int gap, hold;
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < VEC_LEN; k++) begin
        if (k > 0 && $urandom_range(0, 9) < 3) vec[k] = vec[$urandom_range(0, k - 1)];
        else vec[k] = rand_float();
      end
      ref_min(exp_data, exp_idx);
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      feed_vector(gap, 1'b0, 1'b0);
      total++; if (got_data !== exp_data) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, got_data, exp_data); end
`ifdef MIN_REDUCE_ARGMIN_EN
      total++; if (got_idx != exp_idx) begin bad++; $display("FAIL rand_idx[%0d]: got %0d want %0d", n, got_idx, exp_idx); end
`endif
      total++; if (got_lat != VEC_LEN + 1) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, got_lat, VEC_LEN + 1); end
      drain(hold, 1'b0);
      total++; if (hold_bad != 0 || end_busy !== 1'b0) begin
        bad++; $display("FAIL rand_drain[%0d]: got hold_bad=%0d busy=%b want 0 0", n, hold_bad, end_busy);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_tie();
    test_out_stall();
    test_gaps();
    test_reset_mid();
    test_start_ignored();
    test_start_with_valid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end
endmodule
